// File: rtl/mesh_stream_loader.sv
// mesh_stream_loader
//   Parses the host mesh word stream (vertex count, vertex coords, face count,
//   face indices, end marker) and writes every word except the end marker into
//   memory in stream order: addr 0 = vertex count, addr V*CPV+1 = face count.
//
// Ports
//   clk, reset    clock and synchronous active-high reset
//   clear         1-cycle pulse: abandon any load and wait for a new vertex count
//   in_valid/in_data/in_ready   stream input, accept = in_valid && in_ready
//   mem_we/mem_addr/mem_wdata   registered memory write port
//   vertex_count, face_count    latched header words
//   word_count    words written so far (one bit wider than the address)
//   load_done     level: complete stream stored with a valid end marker
//   load_error    level: capacity overflow or bad end marker
module mesh_stream_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    CPV        = 3,
    parameter int                    IPF        = 3,
    parameter logic [DATA_WIDTH-1:0] END_MARKER = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] vertex_count,
    output logic [DATA_WIDTH-1:0] face_count,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  load_done,
    output logic                  load_error
);

    // Remaining-word arithmetic is wide enough for count * 4 with no truncation;
    // the capacity compare is wider still so the sums cannot wrap either.
    localparam int RW = DATA_WIDTH + 3;
    localparam int CW = ((RW > ADDR_WIDTH + 1) ? RW : ADDR_WIDTH + 1) + 2;
    localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_VCOUNT, S_VERTS, S_FCOUNT, S_FACES, S_END, S_DONE, S_ERROR
    } state_t;

    state_t        state;
    logic [RW-1:0] remaining;
    logic          accept;
    logic [RW-1:0] v_words, f_words;
    logic [CW-1:0] v_need, f_need;
    logic          v_ovf, f_ovf;
    logic          wr_en;

    assign in_ready = (state != S_DONE) && (state != S_ERROR);
    assign accept   = in_valid && in_ready;

    assign v_words = RW'(in_data) * RW'(CPV);
    assign f_words = RW'(in_data) * RW'(IPF);

    // At the vertex-count word the face-count word must also fit, otherwise the
    // stream is already known to be unstorable: count word + coords + face count.
    assign v_need = CW'(word_count) + CW'(v_words) + CW'(2);
    // At the face-count word: count word + indices.
    assign f_need = CW'(word_count) + CW'(f_words) + CW'(1);
    assign v_ovf  = v_need > DEPTH;
    assign f_ovf  = f_need > DEPTH;

    // A count word that would overflow memory is rejected without being written.
    always_comb begin
        wr_en = 1'b0;
        if (accept) begin
            case (state)
                S_VCOUNT: wr_en = !v_ovf;
                S_FCOUNT: wr_en = !f_ovf;
                S_VERTS,
                S_FACES:  wr_en = 1'b1;
                default:  wr_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_VCOUNT;
            remaining    <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            vertex_count <= '0;
            face_count   <= '0;
            word_count   <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            // The write stage is not touched by clear: a word accepted in the
            // clear cycle still lands in memory one cycle later.
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr   <= word_count[ADDR_WIDTH-1:0];
                mem_wdata  <= in_data;
                word_count <= word_count + 1'b1;
            end

            if (clear) begin
                state        <= S_VCOUNT;
                remaining    <= '0;
                vertex_count <= '0;
                face_count   <= '0;
                word_count   <= '0;
                load_done    <= 1'b0;
                load_error   <= 1'b0;
            end else if (accept) begin
                case (state)
                    S_VCOUNT: begin
                        vertex_count <= in_data;
                        remaining    <= v_words;
                        if (v_ovf) begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end else if (v_words == '0) begin
                            state <= S_FCOUNT;
                        end else begin
                            state <= S_VERTS;
                        end
                    end
                    S_VERTS: begin
                        remaining <= remaining - 1'b1;
                        if (remaining == RW'(1)) state <= S_FCOUNT;
                    end
                    S_FCOUNT: begin
                        face_count <= in_data;
                        remaining  <= f_words;
                        if (f_ovf) begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end else if (f_words == '0) begin
                            state <= S_END;
                        end else begin
                            state <= S_FACES;
                        end
                    end
                    S_FACES: begin
                        remaining <= remaining - 1'b1;
                        if (remaining == RW'(1)) state <= S_END;
                    end
                    S_END: begin
                        if (in_data == END_MARKER) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                        end else begin
                            state      <= S_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule
